// File: rtl/aurora_params.sv
// Shared parameters and types for the Aurora transport blocks.
//   ARB_SRC_CNT : default requester count of the TX arbiter
//   arb_state_t : TX arbiter FSM states
package aurora_params;
  localparam int ARB_SRC_CNT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;
endpackage

// File: rtl/aurora_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : highest-priority index this round
//   gnt_idx : first set request at or after ptr (modulo N)
//   any     : at least one request set
module aurora_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);
  localparam int W = $clog2(N);

  // (a + b) mod N for a, b < N; the W+1 bit sum cannot overflow.
  function automatic logic [W-1:0] wrap(input logic [W:0] s);
    return (s >= (W+1)'(N)) ? W'(s - (W+1)'(N)) : W'(s);
  endfunction

  logic [N-1:0] rot;
  logic [W-1:0] first;

  always_comb begin
    rot   = '0;
    first = '0;
    any   = |req;
    // rotate so that ptr lands at bit 0
    for (int k = 0; k < N; k++)
      rot[k] = req[wrap({1'b0, ptr} + (W+1)'(k))];
    // lowest set bit wins
    for (int k = N-1; k >= 0; k--)
      if (rot[k]) first = W'(k);
    // un-rotate back to a source index
    gnt_idx = wrap({1'b0, ptr} + {1'b0, first});
  end
endmodule

// File: rtl/aurora_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one Aurora TX stream among
// SRC_CNT AXI-S sources. A grant lasts a whole frame; new grants only
// while channel_up. A frame cut by link loss is drained at the source.
//   clk, rst (sync, active-low), channel_up
//   i_t*      : per-source AXI-S slave ports (i_tready combinational)
//   o_t*      : merged AXI-S master port (registered)
//   stat_grant, stat_busy, stat_drop_cnt : status
module aurora_tx_arbiter
  import aurora_params::*;
#(
  parameter int SRC_CNT = ARB_SRC_CNT,
  parameter int DATA_W  = 128,
  parameter int KEEP_W  = DATA_W/8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            channel_up,
  input  logic [SRC_CNT-1:0][DATA_W-1:0]  i_tdata,
  input  logic [SRC_CNT-1:0][KEEP_W-1:0]  i_tkeep,
  input  logic [SRC_CNT-1:0]              i_tvalid,
  input  logic [SRC_CNT-1:0]              i_tlast,
  output logic [SRC_CNT-1:0]              i_tready,
  output logic [DATA_W-1:0]               o_tdata,
  output logic [KEEP_W-1:0]               o_tkeep,
  output logic                            o_tvalid,
  output logic                            o_tlast,
  input  logic                            o_tready,
  output logic [$clog2(SRC_CNT)-1:0]      stat_grant,
  output logic                            stat_busy,
  output logic [15:0]                     stat_drop_cnt
);
  localparam int GW = $clog2(SRC_CNT);

  arb_state_t           state_q, state_d;
  logic [GW-1:0]        ptr_q, ptr_d, grant_q, grant_d;
  logic [15:0]          drop_q, drop_d;
  logic                 tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DATA_W-1:0]    tdata_q, tdata_d;
  logic [KEEP_W-1:0]    tkeep_q, tkeep_d;
  logic [GW-1:0]        pick_idx;
  logic                 pick_any, fwd_rdy, src_vld, src_last;

  aurora_rr_pick #(.N(SRC_CNT)) u_pick (
    .req     (i_tvalid),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    drop_d   = drop_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    i_tready = '0;
    fwd_rdy  = !tvalid_q || o_tready;
    src_vld  = i_tvalid[grant_q];
    src_last = i_tlast[grant_q];

    // pending beat leaves; a load below overrides this
    if (o_tready) tvalid_d = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (channel_up && pick_any) begin
          grant_d = pick_idx;
          ptr_d   = (pick_idx == GW'(SRC_CNT-1)) ? '0 : pick_idx + 1'b1;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        i_tready[grant_q] = fwd_rdy;
        if (src_vld && fwd_rdy) begin
          tvalid_d = 1'b1;
          tdata_d  = i_tdata[grant_q];
          tkeep_d  = i_tkeep[grant_q];
          tlast_d  = src_last;
        end
        // an accepted tlast wins over a simultaneous link drop
        if (src_vld && fwd_rdy && src_last) state_d = ARB_IDLE;
        else if (!channel_up)               state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        i_tready[grant_q] = 1'b1;
        if (src_vld && src_last) begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      drop_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      drop_q   <= drop_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
    end
  end

  assign o_tdata       = tdata_q;
  assign o_tkeep       = tkeep_q;
  assign o_tvalid      = tvalid_q;
  assign o_tlast       = tlast_q;
  assign stat_grant    = grant_q;
  assign stat_busy     = (state_q != ARB_IDLE);
  assign stat_drop_cnt = drop_q;
endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Directed bench for aurora_tx_arbiter: per-cycle vector table plus
// hand-written backpressure and mid-frame reset sequences.
module tb_aurora_tx_arbiter;
  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  channel_up = 1'b1;
  logic [3:0][127:0]     i_tdata;
  logic [3:0][15:0]      i_tkeep;
  logic [3:0]            i_tvalid = '0;
  logic [3:0]            i_tlast  = '0;
  logic [3:0]            i_tready;
  logic [127:0]          o_tdata;
  logic [15:0]           o_tkeep;
  logic                  o_tvalid, o_tlast;
  logic                  o_tready = 1'b1;
  logic [1:0]            stat_grant;
  logic                  stat_busy;
  logic [15:0]           stat_drop_cnt;

  aurora_tx_arbiter #(.SRC_CNT(4), .DATA_W(128), .KEEP_W(16)) dut (
    .clk(clk), .rst(rst), .channel_up(channel_up),
    .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tvalid(i_tvalid),
    .i_tlast(i_tlast), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tvalid(o_tvalid),
    .o_tlast(o_tlast), .o_tready(o_tready),
    .stat_grant(stat_grant), .stat_busy(stat_busy),
    .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One row per cycle. Inputs are driven at the falling edge; outputs are
  // checked 1 time unit later. Source s drives tdata = row*16 + s, so a
  // beat accepted on row k from source g reappears as k*16+g.
  typedef struct {
    logic        rst;
    logic        cu;
    logic [3:0]  tv;
    logic [3:0]  tl;
    logic [3:0]  irdy;
    logic        ov;
    logic        ol;
    logic [11:0] od;
    logic [1:0]  g;
    logic        busy;
    logic [15:0] drop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic cu, input logic [3:0] tv, input logic [3:0] tl,
                     input logic [3:0] irdy, input logic ov, input logic ol, input logic [11:0] od,
                     input logic [1:0] g, input logic busy, input logic [15:0] drop);
    vec_t v;
    v.rst = r; v.cu = cu; v.tv = tv; v.tl = tl; v.irdy = irdy; v.ov = ov;
    v.ol = ol; v.od = od; v.g = g; v.busy = busy; v.drop = drop;
    tbl.push_back(v);
  endtask

  initial begin
    logic [127:0] held;
    logic         stall_prev;
    logic         s_rdy, s_ov;
    logic [127:0] s_od;
    int           sent, recv;

    for (int s = 0; s < 4; s++) begin
      i_tdata[s] = '0;
      i_tkeep[s] = 16'hFFFF >> s;
    end

    //   rst cu  tv    tl     irdy  ov ol od      g  busy drop
    // single source: src2, 3 beats
    add(0, 1, 4'h0, 4'h0,  4'h0, 0, 0, 12'h0,   0, 0, 0);   // 0
    add(1, 1, 4'h4, 4'h0,  4'h0, 0, 0, 12'h0,   0, 0, 0);   // 1
    add(1, 1, 4'h4, 4'h0,  4'h4, 0, 0, 12'h0,   2, 1, 0);   // 2
    add(1, 1, 4'h4, 4'h0,  4'h4, 1, 0, 12'h22,  2, 1, 0);   // 3
    add(1, 1, 4'h4, 4'h4,  4'h4, 1, 0, 12'h32,  2, 1, 0);   // 4
    add(1, 1, 4'h0, 4'h0,  4'h0, 1, 1, 12'h42,  2, 0, 0);   // 5
    add(0, 1, 4'h0, 4'h0,  4'h0, 0, 0, 12'h0,   2, 0, 0);   // 6 reset -> ptr 0
    // all four contending, 2-beat frames: order 0,1,2,3,0,1
    add(1, 1, 4'hF, 4'h0,  4'h0, 0, 0, 12'h0,   0, 0, 0);   // 7
    add(1, 1, 4'hF, 4'h0,  4'h1, 0, 0, 12'h0,   0, 1, 0);   // 8
    add(1, 1, 4'hF, 4'hF,  4'h1, 1, 0, 12'h80,  0, 1, 0);   // 9
    add(1, 1, 4'hF, 4'h0,  4'h0, 1, 1, 12'h90,  0, 0, 0);   // 10
    add(1, 1, 4'hF, 4'h0,  4'h2, 0, 0, 12'h0,   1, 1, 0);   // 11
    add(1, 1, 4'hF, 4'hF,  4'h2, 1, 0, 12'hB1,  1, 1, 0);   // 12
    add(1, 1, 4'hF, 4'h0,  4'h0, 1, 1, 12'hC1,  1, 0, 0);   // 13
    add(1, 1, 4'hF, 4'h0,  4'h4, 0, 0, 12'h0,   2, 1, 0);   // 14
    add(1, 1, 4'hF, 4'hF,  4'h4, 1, 0, 12'hE2,  2, 1, 0);   // 15
    add(1, 1, 4'hF, 4'h0,  4'h0, 1, 1, 12'hF2,  2, 0, 0);   // 16
    add(1, 1, 4'hF, 4'h0,  4'h8, 0, 0, 12'h0,   3, 1, 0);   // 17
    add(1, 1, 4'hF, 4'hF,  4'h8, 1, 0, 12'h113, 3, 1, 0);   // 18
    add(1, 1, 4'hF, 4'h0,  4'h0, 1, 1, 12'h123, 3, 0, 0);   // 19
    add(1, 1, 4'hF, 4'h0,  4'h1, 0, 0, 12'h0,   0, 1, 0);   // 20
    add(1, 1, 4'hF, 4'hF,  4'h1, 1, 0, 12'h140, 0, 1, 0);   // 21
    add(1, 1, 4'hF, 4'h0,  4'h0, 1, 1, 12'h150, 0, 0, 0);   // 22
    add(1, 1, 4'hF, 4'h0,  4'h2, 0, 0, 12'h0,   1, 1, 0);   // 23
    add(1, 1, 4'hF, 4'hF,  4'h2, 1, 0, 12'h171, 1, 1, 0);   // 24
    add(1, 1, 4'h0, 4'h0,  4'h0, 1, 1, 12'h181, 1, 0, 0);   // 25
    // link loss: src1 sends 2 of 6 beats, then link drops
    add(1, 1, 4'h2, 4'h0,  4'h0, 0, 0, 12'h0,   1, 0, 0);   // 26
    add(1, 1, 4'h2, 4'h0,  4'h2, 0, 0, 12'h0,   1, 1, 0);   // 27
    add(1, 1, 4'h2, 4'h0,  4'h2, 1, 0, 12'h1B1, 1, 1, 0);   // 28
    add(1, 0, 4'h0, 4'h0,  4'h2, 1, 0, 12'h1C1, 1, 1, 0);   // 29
    add(1, 0, 4'h2, 4'h0,  4'h2, 0, 0, 12'h0,   1, 1, 0);   // 30
    add(1, 0, 4'h2, 4'h0,  4'h2, 0, 0, 12'h0,   1, 1, 0);   // 31
    add(1, 0, 4'h2, 4'h0,  4'h2, 0, 0, 12'h0,   1, 1, 0);   // 32
    add(1, 0, 4'h2, 4'h2,  4'h2, 0, 0, 12'h0,   1, 1, 0);   // 33
    add(1, 0, 4'hF, 4'h0,  4'h0, 0, 0, 12'h0,   1, 0, 1);   // 34 no grant while down
    add(1, 0, 4'hF, 4'h0,  4'h0, 0, 0, 12'h0,   1, 0, 1);   // 35
    // link drop coinciding with src0's tlast
    add(1, 1, 4'h1, 4'h0,  4'h0, 0, 0, 12'h0,   1, 0, 1);   // 36
    add(1, 1, 4'h1, 4'h0,  4'h1, 0, 0, 12'h0,   0, 1, 1);   // 37
    add(1, 0, 4'h1, 4'h1,  4'h1, 1, 0, 12'h250, 0, 1, 1);   // 38
    add(1, 0, 4'h0, 4'h0,  4'h0, 1, 1, 12'h260, 0, 0, 1);   // 39
    add(1, 1, 4'h0, 4'h0,  4'h0, 0, 0, 12'h0,   0, 0, 1);   // 40

    repeat (2) @(posedge clk);
    #1;
    chk("reset_tdata", o_tdata, '0);
    chk("reset_tkeep", 128'(o_tkeep), '0);
    chk("reset_tlast", 128'(o_tlast), '0);

    foreach (tbl[k]) begin
      @(negedge clk);
      rst        = tbl[k].rst;
      channel_up = tbl[k].cu;
      i_tvalid   = tbl[k].tv;
      i_tlast    = tbl[k].tl;
      o_tready   = 1'b1;
      for (int s = 0; s < 4; s++) i_tdata[s] = 128'(k*16 + s);
      #1;
      chk($sformatf("r%0d_irdy", k), 128'(i_tready), 128'(tbl[k].irdy));
      chk($sformatf("r%0d_ovalid", k), 128'(o_tvalid), 128'(tbl[k].ov));
      chk($sformatf("r%0d_grant", k), 128'(stat_grant), 128'(tbl[k].g));
      chk($sformatf("r%0d_busy", k), 128'(stat_busy), 128'(tbl[k].busy));
      chk($sformatf("r%0d_drop", k), 128'(stat_drop_cnt), 128'(tbl[k].drop));
      if (tbl[k].ov) begin
        chk($sformatf("r%0d_tdata", k), o_tdata, 128'(tbl[k].od));
        chk($sformatf("r%0d_tlast", k), 128'(o_tlast), 128'(tbl[k].ol));
        chk($sformatf("r%0d_tkeep", k), 128'(o_tkeep), 128'(16'hFFFF >> tbl[k].g));
      end
    end

    // Backpressure: src3 sends A0..A4, o_tready low for 5 cycles mid-frame.
    channel_up = 1'b1;
    sent = 0; recv = 0; stall_prev = 1'b0; held = '0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      o_tready   = !(c >= 4 && c < 9);
      i_tvalid   = (sent < 5) ? 4'h8 : 4'h0;
      i_tlast    = (sent == 4) ? 4'h8 : 4'h0;
      i_tdata[3] = 128'(32'hA0 + sent);
      #1;
      s_rdy = i_tready[3];
      s_ov  = o_tvalid;
      s_od  = o_tdata;
      if (s_ov && !o_tready) begin
        chk($sformatf("bp%0d_irdy", c), 128'(s_rdy), '0);
        if (stall_prev) chk($sformatf("bp%0d_hold", c), s_od, held);
        held = s_od;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      @(posedge clk);
      if (s_ov && o_tready) begin
        chk($sformatf("bp_beat%0d", recv), s_od, 128'(32'hA0 + recv));
        recv++;
      end
      if (s_rdy && i_tvalid[3]) sent++;
    end
    chk("bp_count", 128'(recv), 128'(5));

    // Reset mid-frame: src2 frame, reset during beat 3, then all request.
    @(negedge clk);
    o_tready = 1'b1;
    i_tvalid = 4'h4;
    i_tlast  = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("mr_irdy_before", 128'(i_tready), 128'(4'h4));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mr_ovalid", 128'(o_tvalid), '0);
    chk("mr_irdy", 128'(i_tready), '0);
    chk("mr_busy", 128'(stat_busy), '0);
    chk("mr_grant", 128'(stat_grant), '0);
    rst      = 1'b1;
    i_tvalid = 4'hF;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mr_regrant", 128'(stat_grant), '0);
    chk("mr_regrant_irdy", 128'(i_tready), 128'(4'h1));
    chk("mr_regrant_busy", 128'(stat_busy), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aurora_tx_arbiter.md
# aurora_tx_arbiter

Packet-level round-robin arbiter that shares one Aurora channel TX stream among `SRC_CNT` AXI-S requesters. It sits in `user_clk` ahead of the per-channel Aurora TX FIFO input of the transport. A grant is held for the whole frame, so frames from different sources never interleave. New grants are gated on `channel_up`; a frame cut by link loss is drained and discarded at the source side.

## Interface
- `SRC_CNT`, 4: number of requesters, 2..16.
- `DATA_W`, 128: AXI-S data width.
- `KEEP_W`, 16: AXI-S keep width, `DATA_W/8`.
- `clk` input 1: clock, connected to Aurora `user_clk`.
- `rst` input 1: reset, synchronous, active-low.
- `channel_up` input 1: link status of the served channel.
- `i_tdata` input `[SRC_CNT-1:0][DATA_W-1:0]`: source data.
- `i_tkeep` input `[SRC_CNT-1:0][KEEP_W-1:0]`: source keep.
- `i_tvalid` input `[SRC_CNT-1:0]`: source valid.
- `i_tlast` input `[SRC_CNT-1:0]`: source end of frame.
- `i_tready` output `[SRC_CNT-1:0]`: source ready.
- `o_tdata` output `DATA_W`: merged stream data.
- `o_tkeep` output `KEEP_W`: merged stream keep.
- `o_tvalid` output 1: merged stream valid.
- `o_tlast` output 1: merged stream end of frame.
- `o_tready` input 1: merged stream ready.
- `stat_grant` output `$clog2(SRC_CNT)`: index of the current or last granted source.
- `stat_busy` output 1: state is not IDLE.
- `stat_drop_cnt` output 16: number of frames discarded in DRAIN, saturating.

## Operation
- FSM states: IDLE, GRANT, DRAIN.
- **IDLE**
  - If `channel_up`=1 and any `i_tvalid` is set, register `grant` as the first valid index at or after `ptr`, with modulo-`SRC_CNT` wrap. Go to GRANT.
  - `ptr` resets to 0. After each selection, `ptr` becomes `grant+1`, with modulo wrap.
  - If `channel_up`=0, stay in IDLE. All `i_tready` are 0.
- **GRANT**
  - `i_tready[grant]` = `!o_tvalid || o_tready`. All other `i_tready` bits are 0.
  - An accepted beat loads the output register (data, keep, last) and sets `o_tvalid`.
  - If the output beat is consumed and no new beat is loaded, `o_tvalid` clears.
  - Accepting a beat with `tlast`=1 returns the FSM to IDLE.
  - If `channel_up` falls while no `tlast` has been accepted, go to DRAIN. The output register still presents its pending beat until it is consumed.
- **DRAIN**
  - `i_tready[grant]`=1 unconditionally. Beats are discarded and never loaded to the output register.
  - Accepting `tlast` increments `stat_drop_cnt` (saturates at 0xFFFF) and returns the FSM to IDLE.
- Link-loss priority: `channel_up` falling in the same cycle that `tlast` is accepted counts as normal completion. The FSM goes to IDLE with no drop.
- Frame boundary: the beat with `tlast` is forwarded intact. The receiver sees a truncated frame only via Aurora loss detection, which is outside this block.
- Sources that deassert `tvalid` mid-frame keep the grant. There is no timeout.

## Timing
- Reset values:
  - FSM state is IDLE, `ptr`=0, `grant`=0.
  - `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0, `o_tkeep`=0.
  - `i_tready`=0, `stat_busy`=0, `stat_drop_cnt`=0.
- Arbitration latency: 1 cycle from IDLE seeing `tvalid` to `i_tready` asserting.
- Pipeline latency: 1 cycle from accepted input beat to `o_tvalid`.
- Throughput: 1 beat/cycle within a frame. One idle input cycle between frames (the IDLE cycle).
- `i_tready` is combinational from `o_tready`, state and `grant`. All other outputs are registered.
- Output AXI-S rule: once `o_tvalid`=1, `o_tdata`, `o_tkeep` and `o_tlast` hold until `o_tready`=1.
- Reset takes effect mid-frame. The output register clears; no partial-frame completion is attempted.

## Structure
- `aurora_params` gains `ARB_SRC_CNT` (default 4) and the FSM state enum `arb_state_t` {IDLE, GRANT, DRAIN}.
- Sub-module `aurora_rr_pick`: purely combinational.
  - Parameter `N`.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `gnt_idx`, `any`.
  - Function: rotate the request vector by `ptr`, priority-encode, un-rotate.
- Top level holds the FSM, output register and drop counter.

## Test plan
- **Single source:** src2 sends a 3-beat frame D0..D2 with `o_tready`=1 → `o_tvalid` for 3 consecutive cycles starting 2 cycles after first `tvalid`; `o_tlast` on D2; `stat_grant`=2.
- **All four contending:** all sources present 2-beat frames continuously → output frame order 0,1,2,3,0,1; no beat interleaving; one bubble between frames.
- **Backpressure:** `o_tready` held 0 for 5 cycles mid-frame → `o_tdata` stable throughout; `i_tready[grant]`=0 while `o_tvalid`=1; no beat lost or duplicated.
- **Link loss mid-frame:** src1 sends beat 2 of a 6-beat frame, then `channel_up`→0 → remaining 4 beats accepted, output stays idle after the pending beat; `stat_drop_cnt`=1; no new grant until `channel_up`=1.
- **Link loss coinciding with tlast:** `channel_up` falls in the same cycle src0's `tlast` is accepted → frame forwarded fully; `stat_drop_cnt` unchanged; FSM goes to IDLE.
- **Reset mid-frame:** `rst`=0 during beat 3 → next cycle `o_tvalid`=0, `i_tready`=0, `ptr`=0; after release, src0 is granted first if valid.
